// File: rtl/key_event.sv
// key_event: gesture decoder for one debounced key.
// Turns the debounce filter's change pulse (key_stable) and level (key_flag,
// 0 = pressed) into one-cycle short / long / double / auto-repeat events.
//
// Handshake: there is no back-pressure. key_flag is only looked at in a cycle
// where key_stable is 1, and every event output is a registered single-cycle
// pulse that the consumer must take in the cycle it is high.
module key_event #(
    parameter int unsigned CNT_W      = 18,
    parameter int unsigned LONG_CNT   = 200_000,
    parameter int unsigned DBL_GAP    = 60_000,
    parameter int unsigned REPEAT_CNT = 40_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_stable,
    input  logic       key_flag,
    output logic       short_p,
    output logic       long_p,
    output logic       double_p,
    output logic       repeat_p,
    output logic       busy,
    output logic [2:0] state_dbg
);

    // Terminal counts: a state has lasted PARAM cycles when cnt reaches PARAM-1.
    localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] DBL_TC    = CNT_W'(DBL_GAP - 1);
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CNT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRESS1 = 3'd1,
        S_WAIT2  = 3'd2,
        S_PRESS2 = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             key_press;
    logic             key_release;

    // Key edges only exist in the cycle the filter reports a change.
    assign key_press   = key_stable & ~key_flag;
    assign key_release = key_stable &  key_flag;

    assign state_dbg = state;

    // Gesture FSM with its shared counter and registered event outputs.
    // A key edge is checked before the terminal count so that it wins a tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            short_p  <= 1'b0;
            long_p   <= 1'b0;
            double_p <= 1'b0;
            repeat_p <= 1'b0;
            busy     <= 1'b0;
        end else begin
            short_p  <= 1'b0;
            long_p   <= 1'b0;
            double_p <= 1'b0;
            repeat_p <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (key_press) begin
                        state <= S_PRESS1;
                        busy  <= 1'b1;
                    end
                end
                S_PRESS1: begin
                    if (key_release) begin
                        state <= S_WAIT2;
                        cnt   <= '0;
                    end else if (cnt == LONG_TC) begin
                        state  <= S_HOLD;
                        cnt    <= '0;
                        long_p <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_WAIT2: begin
                    if (key_press) begin
                        state <= S_PRESS2;
                        cnt   <= '0;
                    end else if (cnt == DBL_TC) begin
                        state   <= S_IDLE;
                        cnt     <= '0;
                        short_p <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_PRESS2: begin
                    if (key_release) begin
                        state    <= S_IDLE;
                        cnt      <= '0;
                        double_p <= 1'b1;
                        busy     <= 1'b0;
                    end else if (cnt == LONG_TC) begin
                        state  <= S_HOLD;
                        cnt    <= '0;
                        long_p <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (key_release) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == REPEAT_TC) begin
                        cnt      <= '0;
                        repeat_p <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_event.sv
// Bench for key_event: directed gestures, boundary ties, resets mid-gesture
// and a random key stream, checked against a timestamp-based gesture model.
module tb_key_event;

    localparam int L = 20;
    localparam int D = 8;
    localparam int R = 5;

    // Event codes packed into the expected queue as {code[2:0], cycle[28:0]}.
    localparam logic [2:0] EV_SHORT  = 3'd1;
    localparam logic [2:0] EV_LONG   = 3'd2;
    localparam logic [2:0] EV_DOUBLE = 3'd3;
    localparam logic [2:0] EV_REPEAT = 3'd4;

    // Gesture phases of the reference model.
    localparam int G_NONE   = 0;
    localparam int G_DOWN1  = 1;
    localparam int G_GAP    = 2;
    localparam int G_DOWN2  = 3;
    localparam int G_LONG   = 4;

    logic       clk;
    logic       rst_n;
    logic       key_stable;
    logic       key_flag;
    logic       short_p;
    logic       long_p;
    logic       double_p;
    logic       repeat_p;
    logic       busy;
    logic [2:0] state_dbg;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit mon_en = 0;

    logic [31:0] exp_q[$];
    int          g_phase = G_NONE;
    int          g_mark  = 0;
    logic        m_busy = 1'b0;
    logic        m_busy_next = 1'b0;

    key_event #(
        .CNT_W      (18),
        .LONG_CNT   (L),
        .DBL_GAP    (D),
        .REPEAT_CNT (R)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_stable (key_stable),
        .key_flag   (key_flag),
        .short_p    (short_p),
        .long_p     (long_p),
        .double_p   (double_p),
        .repeat_p   (repeat_p),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one call per sampling edge e. Times are absolute edge
    // indices; an event decided at edge e is visible in cycle e+1.
    task automatic model_step(input logic ks, input logic kf);
        int   e;
        logic prs;
        logic rel;
        logic [2:0] ev;
        e   = cyc;
        prs = ks & ~kf;
        rel = ks & kf;
        ev  = 3'd0;
        case (g_phase)
            G_NONE:  if (prs) begin g_phase = G_DOWN1; g_mark = e; end
            G_DOWN1: if (rel) begin g_phase = G_GAP; g_mark = e; end
                     else if (e - g_mark == L) begin ev = EV_LONG; g_phase = G_LONG; g_mark = e; end
            G_GAP:   if (prs) begin g_phase = G_DOWN2; g_mark = e; end
                     else if (e - g_mark == D) begin ev = EV_SHORT; g_phase = G_NONE; end
            G_DOWN2: if (rel) begin ev = EV_DOUBLE; g_phase = G_NONE; end
                     else if (e - g_mark == L) begin ev = EV_LONG; g_phase = G_LONG; g_mark = e; end
            G_LONG:  if (rel) g_phase = G_NONE;
                     else if ((e - g_mark) % R == 0) ev = EV_REPEAT;
            default: g_phase = G_NONE;
        endcase
        if (ev != 3'd0) exp_q.push_back({ev, 29'(e + 1)});
        m_busy_next = (g_phase != G_NONE);
    endtask

    // Driver tasks: inputs change 1 time unit after the active edge.
    task automatic step(input logic ks, input logic kf);
        key_stable = ks;
        key_flag   = kf;
        model_step(ks, kf);
        @(posedge clk);
        cyc++;
        m_busy = m_busy_next;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, $urandom_range(0, 1) == 1);
    endtask

    task automatic key_ev(input logic kf);
        step(1'b1, kf);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({short_p, long_p, double_p, repeat_p, busy} !== 5'b0) begin
            errors++;
            $display("FAIL %s: outputs s/l/d/r/b=%b required 00000", name,
                     {short_p, long_p, double_p, repeat_p, busy});
        end
    endtask

    // Reset held for n cycles with random inputs, then released cleanly.
    task automatic reset_for(input int n, input string name);
        mon_en = 0;
        rst_n  = 1'b0;
        #1;
        check_zero({name, "_assert"});
        for (int i = 0; i < n; i++) begin
            key_stable = $urandom_range(0, 1) == 1;
            key_flag   = $urandom_range(0, 1) == 1;
            @(negedge clk);
            check_zero({name, "_held"});
            @(posedge clk);
            cyc++;
            #1;
        end
        key_stable  = 1'b0;
        rst_n       = 1'b1;
        g_phase     = G_NONE;
        exp_q.delete();
        m_busy      = 1'b0;
        m_busy_next = 1'b0;
        mon_en      = 1;
    endtask

    // Scoreboard monitor: samples on the falling edge, pops on every pulse.
    always @(negedge clk) begin : monitor
        int          npulse;
        logic [2:0]  code;
        logic [31:0] ex;
        if (mon_en) begin
            npulse = int'(short_p) + int'(long_p) + int'(double_p) + int'(repeat_p);
            checks++;
            if (npulse > 1) begin
                errors++;
                $display("FAIL onehot @%0d: %0d pulses high, required at most 1", cyc, npulse);
            end
            checks++;
            if (busy !== m_busy) begin
                errors++;
                $display("FAIL busy @%0d: got %b required %b", cyc, busy, m_busy);
            end
            code = short_p  ? EV_SHORT  :
                   long_p   ? EV_LONG   :
                   double_p ? EV_DOUBLE :
                   repeat_p ? EV_REPEAT : 3'd0;
            if (npulse > 0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event @%0d: code %0d, required none", cyc, code);
                end else begin
                    ex = exp_q.pop_front();
                    if (ex[31:29] != code || ex[28:0] != 29'(cyc)) begin
                        errors++;
                        $display("FAIL event @%0d: code %0d, required code %0d at cycle %0d",
                                 cyc, code, ex[31:29], ex[28:0]);
                    end
                end
            end else if (exp_q.size() > 0 && int'(exp_q[0][28:0]) <= cyc) begin
                checks++;
                errors++;
                ex = exp_q.pop_front();
                $display("FAIL missed_event @%0d: no pulse, required code %0d", cyc, ex[31:29]);
            end
        end
    end

    // Stimulus
    initial begin
        rst_n      = 1'b0;
        key_stable = 1'b0;
        key_flag   = 1'b1;

        // Reset state with random inputs, then a stray release after reset.
        for (int i = 0; i < 4; i++) begin
            key_stable = $urandom_range(0, 1) == 1;
            key_flag   = $urandom_range(0, 1) == 1;
            @(negedge clk);
            check_zero("reset_state");
        end
        @(posedge clk);
        #1;
        reset_for(0, "reset_release");
        idle(2);
        key_ev(1'b1);
        idle(5);

        // Short press: press, release 5 cycles later.
        key_ev(1'b0); idle(4); key_ev(1'b1); idle(14);
        // Double click: press, release @4, press @10, release @14.
        key_ev(1'b0); idle(3); key_ev(1'b1); idle(5); key_ev(1'b0); idle(3); key_ev(1'b1); idle(12);
        // Long press with repeats, released @42.
        key_ev(1'b0); idle(41); key_ev(1'b1); idle(12);
        // Release on the long-press terminal cycle: release wins, then short.
        key_ev(1'b0); idle(L - 1); key_ev(1'b1); idle(D + 4);
        // Second press on the double-gap terminal cycle: press wins.
        key_ev(1'b0); idle(2); key_ev(1'b1); idle(D - 1); key_ev(1'b0); idle(3); key_ev(1'b1); idle(12);
        // Second press held into a long press, with a repeat.
        key_ev(1'b0); idle(2); key_ev(1'b1); idle(3); key_ev(1'b0); idle(L + R + 2); key_ev(1'b1); idle(5);
        // Redundant presses / releases are ignored.
        key_ev(1'b0); idle(1); key_ev(1'b0); idle(2); key_ev(1'b1); idle(2); key_ev(1'b1); idle(14);

        // Reset in HOLD, then in WAIT2.
        key_ev(1'b0); idle(L + 3);
        reset_for(3, "reset_hold");
        idle(L + 5);
        key_ev(1'b0); idle(3); key_ev(1'b1); idle(3);
        reset_for(2, "reset_wait2");
        idle(D + 6);

        // Random key stream with gaps spanning all thresholds.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 8) key_ev(g_phase == G_NONE || g_phase == G_GAP ? 1'b0 : 1'b1);
            else key_ev($urandom_range(0, 1) == 1);
            idle($urandom_range(1, 30));
        end
        key_ev(1'b1);
        idle(L + D + 4);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected events left, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
